mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16x16 shift-add multiplier between two requesters. It accepts operand pairs, starts the multiplier, waits for its Done flag, captures the 32-bit product and returns it to the winning requester with a one-cycle acknowledge. It sits between the multiplier unit and its clients: the MULT path of the CPU (port 0) and an auxiliary client (port 1).

---
 rtl/mult_arbiter.sv | 127 ++++++++++++
 tb/tb_mult_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter/sequencer sharing one 16x16 shift-add
// multiplier between two requesters (port 0 = CPU MULT path, port 1 = aux).
// Optional feature: define MULT_ARB_WATCHDOG_EN to enable a WAIT-state
// watchdog that aborts a transaction after TIMEOUT cycles with Err = 1.
module mult_arbiter #(
  parameter int TIMEOUT = 40
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [15:0] A0,
  input  logic [15:0] B0,
  input  logic [15:0] A1,
  input  logic [15:0] B1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [31:0] Result,
  output logic        Err,
  output logic        Busy,
  output logic        M_St,
  output logic [15:0] M_A,
  output logic [15:0] M_B,
  input  logic        M_Idle,
  input  logic        M_Done,
  input  logic [31:0] M_Prod
);

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mult_arbiter: TIMEOUT must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t state;
  logic   owner;   // port that owns the current transaction
  logic   last;    // port served most recently; 1 after reset so port 0 wins the first tie
  logic   pick0;   // port 0 wins the arbitration this cycle

  // Port 0 wins when it is the only requester, or on a tie when port 1 was served last.
  assign pick0 = Req0 && (!Req1 || last);

  // Start is a direct function of the multiplier being idle while we sit in START.
  assign M_St = (state == START) && M_Idle;

`ifdef MULT_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt;
  logic       err_q;
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  // Sequencer: grant, start the multiplier, wait for its product, acknowledge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      Ack0   <= 1'b0;
      Ack1   <= 1'b0;
      Busy   <= 1'b0;
      Result <= '0;
      M_A    <= '0;
      M_B    <= '0;
`ifdef MULT_ARB_WATCHDOG_EN
      wd_cnt <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      // Acks are single-cycle pulses; they are only set on the way into RESP.
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            owner <= !pick0;
            M_A   <= pick0 ? A0 : A1;
            M_B   <= pick0 ? B0 : B1;
            Busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (M_Idle) begin
            state <= WAIT;
`ifdef MULT_ARB_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (M_Done) begin
            Result <= M_Prod;
            Ack0   <= !owner;
            Ack1   <= owner;
            state  <= RESP;
`ifdef MULT_ARB_WATCHDOG_EN
            err_q  <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            // Multiplier never finished: report a zero product with Err.
            Result <= '0;
            err_q  <= 1'b1;
            Ack0   <= !owner;
            Ack1   <= owner;
            state  <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
`endif
          end
        end
        RESP: begin
          last  <= owner;
          Busy  <= 1'b0;
          state <= IDLE;
`ifdef MULT_ARB_WATCHDOG_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed vectors, tie/reset/start-hold sequences and a
// randomized two-requester run for mult_arbiter. Define MULT_ARB_WATCHDOG_EN
// to also exercise the WAIT-state watchdog (TIMEOUT = 10).
module tb_mult_arbiter;

`ifdef MULT_ARB_WATCHDOG_EN
  localparam int TO = 10;
`else
  localparam int TO = 40;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [15:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic        Ack0, Ack1, Err, Busy, M_St;
  logic [31:0] Result;
  logic [15:0] M_A, M_B;
  logic        M_Idle, M_Done;
  logic [31:0] M_Prod;

  mult_arbiter #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Ack0(Ack0), .Ack1(Ack1), .Result(Result), .Err(Err), .Busy(Busy),
    .M_St(M_St), .M_A(M_A), .M_B(M_B),
    .M_Idle(M_Idle), .M_Done(M_Done), .M_Prod(M_Prod)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endfunction

  // Behavioural multiplier: product appears dly cycles after the start edge.
  logic        m_free, m_done;
  logic        hold = 1'b0;
  logic        no_done = 1'b0;
  int          m_cnt;
  int          dly = 2;
  int          n_start = 0;
  logic [31:0] m_prod;

  assign M_Idle = m_free && !hold;
  assign M_Done = m_done;
  assign M_Prod = m_prod;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_free <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (M_St && !no_done) begin
        n_start <= n_start + 1;
        m_free  <= 1'b0;
        m_cnt   <= (dly > 0) ? dly : 1 + int'($urandom_range(3, 0));
        m_prod  <= 32'(M_A) * 32'(M_B);
      end else if (!m_free) begin
        if (m_cnt <= 1) begin
          m_done <= 1'b1;
          m_free <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Protocol monitor and acknowledge log.
  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        other;
  } ack_t;
  ack_t ack_log[$];
  int   mon_bad = 0;
  int   n_acks  = 0;
  bit   log_en  = 1'b0;

  always @(posedge Clk) begin
    ack_t e;
    #1;
    if (Ack0 && Ack1) mon_bad++;
    if (M_St && (!Busy || Ack0 || Ack1)) mon_bad++;
    if (Ack0 || Ack1) begin
      n_acks++;
      if (log_en) begin
        e.port  = Ack1;
        e.res   = Result;
        e.other = Ack1 ? Req0 : Req1;
        ack_log.push_back(e);
      end
    end
  end

  typedef struct {
    logic        port;
    logic [15:0] a;
    logic [15:0] b;
    int          hold;
    bit          chg;
    logic [31:0] exp;
  } vec_t;

  task automatic set_req(input logic port, input logic [15:0] a, input logic [15:0] b);
    if (port) begin A1 = a; B1 = b; Req1 = 1'b1; end
    else      begin A0 = a; B0 = b; Req0 = 1'b1; end
  endtask

  // Wait (bounded) for any Ack; returns at the falling edge of the Ack cycle.
  task automatic wait_ack(output logic p, output logic [31:0] r, output bit ok);
    ok = 1'b0; p = 1'b0; r = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (Ack0 || Ack1) begin
        p = Ack1; r = Result; ok = 1'b1;
        return;
      end
    end
  endtask

  // One isolated transaction with latency, operand-change and start-hold checks.
  task automatic run_one(input vec_t v, input string nm);
    int lat;
    @(negedge Clk);
    set_req(v.port, v.a, v.b);
    hold = (v.hold > 0);
    @(posedge Clk);
    lat = 1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge Clk);
      chk({nm, " st_held"}, {31'd0, M_St}, 32'd0);
      @(posedge Clk);
      lat++;
    end
    if (v.hold > 0) begin
      @(negedge Clk);
      hold = 1'b0;
      #1;
      chk({nm, " st_pulse"}, {31'd0, M_St}, 32'd1);
      @(posedge Clk);
      lat++;
    end
    for (int k = 0; ; k++) begin
      @(negedge Clk);
      if (Ack0 || Ack1) break;
      if (k == 0 && v.chg) begin
        if (v.port) A1 = 16'h0; else A0 = 16'h0;
      end
      if (lat > 100) begin
        chk({nm, " ack_timeout"}, 32'd0, 32'd1);
        Req0 = 1'b0; Req1 = 1'b0;
        return;
      end
      @(posedge Clk);
      lat++;
    end
    chk({nm, " ack_port"}, {30'd0, Ack1, Ack0}, v.port ? 32'd2 : 32'd1);
    chk({nm, " result"}, Result, v.exp);
    chk({nm, " latency"}, 32'(lat), 32'(3 + dly + v.hold));
    chk({nm, " busy_in_ack"}, {31'd0, Busy}, 32'd1);
    chk({nm, " err"}, {31'd0, Err}, 32'd0);
    Req0 = 1'b0; Req1 = 1'b0;
    @(negedge Clk);
    chk({nm, " busy_after"}, {30'd0, Busy, Ack0 | Ack1}, 32'd0);
    chk({nm, " result_hold"}, Result, v.exp);
  endtask

  // Independent randomized requester for one port.
  logic [31:0] exp_q0[$], exp_q1[$];
  bit          to0 = 1'b0, to1 = 1'b0;

  task automatic requester(input logic port, input int n);
    logic [15:0] a, b;
    bit got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(3, 1)) @(negedge Clk);
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(3, 0) == 0) a = 16'hFFFF;
      set_req(port, a, b);
      if (port) exp_q1.push_back(32'(a) * 32'(b));
      else      exp_q0.push_back(32'(a) * 32'(b));
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge Clk);
        got = port ? Ack1 : Ack0;
      end
      if (port) Req1 = 1'b0; else Req0 = 1'b0;
      if (!got) begin
        if (port) to1 = 1'b1; else to0 = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    vec_t        tbl[7];
    logic        p;
    logic [31:0] r;
    bit          ok;
    int          acks0, starts0;

    tbl[0] = '{port:1'b0, a:16'h0003, b:16'h0005, hold:0, chg:1'b0, exp:32'h0000000F};
    tbl[1] = '{port:1'b1, a:16'h0007, b:16'h0009, hold:0, chg:1'b0, exp:32'h0000003F};
    tbl[2] = '{port:1'b0, a:16'hFFFF, b:16'hFFFF, hold:0, chg:1'b0, exp:32'hFFFE0001};
    tbl[3] = '{port:1'b1, a:16'h0000, b:16'h1234, hold:0, chg:1'b0, exp:32'h00000000};
    tbl[4] = '{port:1'b0, a:16'h8000, b:16'h0002, hold:0, chg:1'b0, exp:32'h00010000};
    tbl[5] = '{port:1'b1, a:16'h1234, b:16'h0010, hold:4, chg:1'b0, exp:32'h00012340};
    tbl[6] = '{port:1'b0, a:16'h0006, b:16'h0007, hold:0, chg:1'b1, exp:32'h0000002A};

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_ack", {30'd0, Ack1, Ack0}, 32'd0);
    chk("rst_ctrl", {29'd0, Busy, M_St, Err}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_mab", {M_A, M_B}, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);

    // Tie after reset: port 0 first, then port 1; port 0 re-requesting at once loses.
    A0 = 16'd7; B0 = 16'd9; A1 = 16'hFFFF; B1 = 16'hFFFF;
    Req0 = 1'b1; Req1 = 1'b1;
    wait_ack(p, r, ok);
    chk("tie1 port", {31'd0, p}, 32'd0);
    chk("tie1 result", r, 32'd63);
    Req0 = 1'b0;
    @(negedge Clk);
    Req0 = 1'b1;
    wait_ack(p, r, ok);
    chk("tie2 port", {31'd0, p}, 32'd1);
    chk("tie2 result", r, 32'hFFFE0001);
    Req1 = 1'b0;
    wait_ack(p, r, ok);
    chk("tie3 port", {31'd0, p}, 32'd0);
    chk("tie3 result", r, 32'd63);
    Req0 = 1'b0;
    @(negedge Clk);

    // Table-driven single transactions
    foreach (tbl[i]) run_one(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for the multiplier
    dly = 6;
    @(negedge Clk);
    set_req(1'b0, 16'd5, 16'd5);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    chk("rstw busy_before", {31'd0, Busy}, 32'd1);
    acks0 = n_acks;
    Rst = 1'b1;
    #1;
    chk("rstw ctrl", {27'd0, Ack1, Ack0, Busy, M_St, Err}, 32'd0);
    chk("rstw result", Result, 32'd0);
    chk("rstw mab", {M_A, M_B}, 32'd0);
    Req0 = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    chk("rstw no_ack", 32'(n_acks), 32'(acks0));
    dly = 2;
    run_one('{port:1'b1, a:16'h00FF, b:16'h0101, hold:0, chg:1'b0, exp:32'h0000FFFF}, "after_rst");

`ifdef MULT_ARB_WATCHDOG_EN
    // Watchdog: the multiplier never reports Done.
    begin
      int lat;
      no_done = 1'b1;
      @(negedge Clk);
      set_req(1'b0, 16'd3, 16'd3);
      @(posedge Clk);
      lat = 1;
      for (int k = 0; k < 100; k++) begin
        @(negedge Clk);
        if (Ack0 || Ack1) break;
        @(posedge Clk);
        lat++;
      end
      chk("wd ack_port", {30'd0, Ack1, Ack0}, 32'd1);
      chk("wd err", {31'd0, Err}, 32'd1);
      chk("wd result", Result, 32'd0);
      chk("wd latency", 32'(lat), 32'(2 + TO));
      Req0 = 1'b0;
      no_done = 1'b0;
      @(negedge Clk);
      chk("wd err_clear", {30'd0, Err, Busy}, 32'd0);
    end
`endif

    // Randomized contention between both ports
    dly = 0;
    @(negedge Clk);
    acks0   = n_acks;
    starts0 = n_start;
    log_en  = 1'b1;
    fork
      requester(1'b0, 30);
      requester(1'b1, 30);
    join
    repeat (3) @(negedge Clk);
    log_en = 1'b0;
    chk("rand timeout", {30'd0, to1, to0}, 32'd0);
    chk("rand n_acks", 32'(ack_log.size()), 32'd60);
    chk("rand starts", 32'(n_start - starts0), 32'(n_acks - acks0));
    for (int i = 0; i < ack_log.size(); i++) begin
      logic [31:0] e;
      if (ack_log[i].port) e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 32'hDEADBEEF;
      else                 e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 32'hDEADBEEF;
      chk($sformatf("rand result %0d", i), ack_log[i].res, e);
      if (i > 0 && ack_log[i-1].other)
        chk($sformatf("rand rr_order %0d", i), {31'd0, ack_log[i].port}, {31'd0, !ack_log[i-1].port});
    end

    chk("protocol monitor", 32'(mon_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
